// File: rtl/spi_note_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_note_pkg
//  Description : Packet layout and receiver state encoding shared by the
//                note-control SPI slave.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_note_pkg;

    localparam int PKT_BITS      = 32;
    localparam int CNT_W         = 5;
    localparam int HDR_BCAST_BIT = 7;
    localparam int HDR_CH_MSB    = 6;
    localparam int HDR_LSB       = 24;
    localparam int FREQ_LSB      = 8;
    localparam int VOL_LSB       = 0;

    typedef enum logic [1:0] {
        ST_WAIT_CS_LOW = 2'd0,
        ST_IDLE        = 2'd1,
        ST_RECV        = 2'd2,
        ST_COMMIT      = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_note_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync
//  Description : Two-flop synchronisers for the SPI pins plus an sck
//                rising-edge detector, all in the clk domain.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sync (
    input  logic clk,
    input  logic reset,
    input  logic chipSelect,
    input  logic sck,
    input  logic sdi,
    output logic cs_s,
    output logic sdi_s,
    output logic sck_rise
);

    logic [1:0] r_cs_q;
    logic [1:0] r_sdi_q;
    logic [2:0] r_sck_q;
    logic [1:0] w_cs_d;
    logic [1:0] w_sdi_d;
    logic [2:0] w_sck_d;

    always_comb begin
        w_cs_d  = {r_cs_q[0], chipSelect};
        w_sdi_d = {r_sdi_q[0], sdi};
        w_sck_d = {r_sck_q[1:0], sck};
    end

    // Chains free-run through reset so they reflect the pins on release.
    always_ff @(posedge clk) begin
        r_cs_q  <= w_cs_d;
        r_sdi_q <= w_sdi_d;
        r_sck_q <= w_sck_d;
    end

    assign cs_s     = r_cs_q[1];
    assign sdi_s    = r_sdi_q[1];
    assign sck_rise = r_sck_q[1] & ~r_sck_q[2] & ~reset;

endmodule
`default_nettype wire

// File: rtl/spi_note_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_note_rx
//  Description : Oversampled SPI slave receiving 32-bit note packets into a
//                per-channel frequency/volume register file.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_note_rx #(
    parameter int FREQ_W   = 12,
    parameter int VOL_W    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         chipSelect,
    input  logic                         sck,
    input  logic                         sdi,
    output logic [CHANNELS*FREQ_W-1:0]   freq,
    output logic [CHANNELS*VOL_W-1:0]    volume,
    output logic                         update,
    output logic [CHANNELS-1:0]          update_mask,
    output logic                         frame_err
);

    import spi_note_pkg::*;

    logic w_cs_s;
    logic w_sdi_s;
    logic w_sck_rise;

    spi_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .chipSelect (chipSelect),
        .sck        (sck),
        .sdi        (sdi),
        .cs_s       (w_cs_s),
        .sdi_s      (w_sdi_s),
        .sck_rise   (w_sck_rise)
    );

    rx_state_t                     r_state_q,  w_state_d;
    logic [CNT_W-1:0]              r_cnt_q,    w_cnt_d;
    logic [PKT_BITS-1:0]           r_shift_q,  w_shift_d;
    logic [CHANNELS*FREQ_W-1:0]    r_freq_q,   w_freq_d;
    logic [CHANNELS*VOL_W-1:0]     r_vol_q,    w_vol_d;
    logic                          r_update_q, w_update_d;
    logic [CHANNELS-1:0]           r_mask_q,   w_mask_d;
    logic                          r_err_q,    w_err_d;

    logic                          w_edge;
    logic                          w_bcast;
    logic [HDR_CH_MSB:0]           w_idx;
    logic                          w_idx_ok;
    logic [PKT_BITS-1:0]           w_shifted;
    logic                          w_unused;

    assign w_edge    = w_sck_rise & w_cs_s;
    assign w_bcast   = r_shift_q[HDR_LSB + HDR_BCAST_BIT];
    assign w_idx     = r_shift_q[HDR_LSB +: HDR_CH_MSB + 1];
    assign w_idx_ok  = (32'(w_idx) < CHANNELS);
    assign w_shifted = {r_shift_q[PKT_BITS-2:0], w_sdi_s};
    // Upper bits of the freq/volume fields are dropped for narrow widths.
    assign w_unused  = ^r_shift_q;

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_shift_d  = r_shift_q;
        w_freq_d   = r_freq_q;
        w_vol_d    = r_vol_q;
        w_update_d = 1'b0;
        w_mask_d   = '0;
        w_err_d    = 1'b0;

        case (r_state_q)
            ST_WAIT_CS_LOW: begin
                w_cnt_d = '0;
                if (!w_cs_s) w_state_d = ST_IDLE;
            end
            ST_IDLE: begin
                w_cnt_d = '0;
                if (w_edge) begin
                    w_shift_d = w_shifted;
                    w_cnt_d   = CNT_W'(1);
                    w_state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (!w_cs_s) begin
                    w_err_d   = (r_cnt_q != '0);
                    w_cnt_d   = '0;
                    w_state_d = ST_IDLE;
                end else if (w_edge) begin
                    w_shift_d = w_shifted;
                    w_cnt_d   = r_cnt_q + CNT_W'(1);
                    if (r_cnt_q == '1) w_state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    if (w_bcast || (32'(w_idx) == ch)) begin
                        w_freq_d[ch*FREQ_W +: FREQ_W] = r_shift_q[FREQ_LSB +: FREQ_W];
                        w_vol_d[ch*VOL_W +: VOL_W]    = r_shift_q[VOL_LSB +: VOL_W];
                        w_mask_d[ch]                  = 1'b1;
                    end
                end
                w_update_d = w_bcast | w_idx_ok;
                w_err_d    = ~(w_bcast | w_idx_ok);
                w_cnt_d    = '0;
                // An edge landing here is the first bit of the next packet.
                if (w_edge) begin
                    w_shift_d = w_shifted;
                    w_cnt_d   = CNT_W'(1);
                end
                w_state_d = w_cs_s ? ST_RECV : ST_IDLE;
            end
            default: w_state_d = ST_WAIT_CS_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= ST_WAIT_CS_LOW;
            r_cnt_q    <= '0;
            r_shift_q  <= '0;
            r_freq_q   <= '0;
            r_vol_q    <= '0;
            r_update_q <= 1'b0;
            r_mask_q   <= '0;
            r_err_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_shift_q  <= w_shift_d;
            r_freq_q   <= w_freq_d;
            r_vol_q    <= w_vol_d;
            r_update_q <= w_update_d;
            r_mask_q   <= w_mask_d;
            r_err_q    <= w_err_d;
        end
    end

    assign freq        = r_freq_q;
    assign volume      = r_vol_q;
    assign update      = r_update_q;
    assign update_mask = r_mask_q;
    assign frame_err   = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_note_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_note_rx
//  Description : Scoreboard bench for spi_note_rx (default and wide instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_note_rx;

    logic         clk = 1'b0;
    logic         reset, cs0, cs1, sck, sdi;
    logic [47:0]  freq;
    logic [31:0]  volume;
    logic         update;
    logic [3:0]   update_mask;
    logic         frame_err;
    logic [127:0] freq1;
    logic [47:0]  volume1;
    logic         update1;
    logic [7:0]   update_mask1;
    logic         frame_err1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;

    typedef struct {
        bit          err;
        logic [3:0]  mask;
        logic [47:0] f;
        logic [31:0] v;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         me;
    logic [47:0]  m_freq;
    logic [31:0]  m_vol;
    int           u1_cnt = 0;
    int           e1_cnt = 0;
    logic [127:0] u1_f;
    logic [47:0]  u1_v;
    logic [7:0]   u1_m;
    logic [31:0]  tail;

    spi_note_rx dut (
        .clk(clk), .reset(reset), .chipSelect(cs0), .sck(sck), .sdi(sdi),
        .freq(freq), .volume(volume), .update(update),
        .update_mask(update_mask), .frame_err(frame_err)
    );

    spi_note_rx #(.FREQ_W(16), .VOL_W(6), .CHANNELS(8)) dut_wide (
        .clk(clk), .reset(reset), .chipSelect(cs1), .sck(sck), .sdi(sdi),
        .freq(freq1), .volume(volume1), .update(update1),
        .update_mask(update_mask1), .frame_err(frame_err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic expect_pkt(input logic [31:0] pkt);
        exp_t       e;
        logic [6:0] idx;
        idx    = pkt[30:24];
        e.mask = 4'd0;
        for (int ch = 0; ch < 4; ch++) begin
            if (pkt[31] || idx == 7'(ch)) begin
                m_freq[ch*12 +: 12] = pkt[19:8];
                m_vol[ch*8 +: 8]    = pkt[7:0];
                e.mask[ch]          = 1'b1;
            end
        end
        e.err = (e.mask == 4'd0);
        e.f   = m_freq;
        e.v   = m_vol;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.err  = 1'b1;
        e.mask = 4'd0;
        e.f    = m_freq;
        e.v    = m_vol;
        exp_q.push_back(e);
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] pkt, input int n);
        for (int i = 0; i < n; i++) begin
            sdi = pkt[31-i];
            half();
            sck = 1'b1;
            last_rise = cyc;
            half();
            sck = 1'b0;
        end
    endtask

    task automatic send0(input logic [31:0] pkt);
        cs0 = 1'b1;
        half();
        shift_bits(pkt, 32);
        half();
        cs0 = 1'b0;
        half();
        half();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (update || frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {update, frame_err}, 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("frame_err", frame_err, me.err);
                    chk("update", update, !me.err);
                    chk("update_mask", update_mask, me.err ? 4'd0 : me.mask);
                    chk("freq", freq, me.f);
                    chk("volume", volume, me.v);
                    if (!me.err) chk("latency_le5", (cyc - last_rise) <= 5, 1);
                end
            end else begin
                chk("mask_idle", update_mask, 0);
            end
        end
        if (update1) begin
            u1_cnt++;
            u1_f = freq1;
            u1_v = volume1;
            u1_m = update_mask1;
        end
        if (frame_err1) e1_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        reset = 1'b1; cs0 = 1'b0; cs1 = 1'b0; sck = 1'b0; sdi = 1'b0;
        m_freq = '0; m_vol = '0;
        repeat (4) @(negedge clk);
        chk("rst_freq", freq, 0);
        chk("rst_volume", volume, 0);
        chk("rst_update", update, 0);
        chk("rst_mask", update_mask, 0);
        chk("rst_frame_err", frame_err, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        expect_pkt(32'h020ABC7F); send0(32'h020ABC7F); drain();
        chk("ch2_freq", freq[35:24], 12'hABC);
        chk("ch2_vol", volume[23:16], 8'h7F);

        expect_pkt(32'h80012340); send0(32'h80012340); drain();

        expect_pkt(32'h050FFFFF); send0(32'h050FFFFF); drain();
        chk("bad_idx_keep", freq, {4{12'h123}});

        expect_err();
        cs0 = 1'b1; half();
        shift_bits(32'h03FFFFFF, 20);
        cs0 = 1'b0; half(); half();
        drain();
        expect_pkt(32'h01045610); send0(32'h01045610); drain();

        expect_pkt(32'h00011111); expect_pkt(32'h03022222);
        cs0 = 1'b1; half();
        shift_bits(32'h00011111, 32);
        shift_bits(32'h03022222, 32);
        half(); cs0 = 1'b0; half(); half();
        drain();

        cs0 = 1'b1; half();
        shift_bits(32'h02055555, 12);
        reset = 1'b1;
        m_freq = '0; m_vol = '0;
        @(negedge clk);
        chk("midrst_freq", freq, 0);
        chk("midrst_volume", volume, 0);
        @(negedge clk);
        reset = 1'b0;
        tail = 32'h02055555 << 12;
        shift_bits(tail, 20);
        half(); cs0 = 1'b0; half(); half();
        drain();
        chk("midrst_no_write", freq, 0);
        expect_pkt(32'h000ABC01); send0(32'h000ABC01); drain();

        cs1 = 1'b1; half();
        shift_bits(32'h020ABC7F, 32);
        half(); cs1 = 1'b0;
        repeat (8) @(negedge clk);
        chk("wide_update_count", u1_cnt, 1);
        chk("wide_freq", u1_f, 128'h0000_0000_0000_0000_0000_0ABC_0000_0000);
        chk("wide_volume", u1_v, 48'h0000_0003_F000);
        chk("wide_mask", u1_m, 8'h04);
        chk("wide_frame_err_count", e1_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
